axi_burst_master: RTL
=====================

// Module: axi_burst_master
// PURPOSE
//  Single-outstanding AXI4 master that turns a command + data-stream interface into INCR bursts.
//  Drives the memory-mapped AXI4 slave block (32-bit data, 1-bit ID) from testbench/DMA-side logic.
//  Write data enters on a valid/ready stream; read data leaves on a valid/ready stream.
//  Completion status is reported with one pulse per command.
// PARAMETERS
//  G_ADDRWIDTH  32  AXI address width
//  G_DATAWIDTH  32  AXI data width; only 32 supported (awsize/arsize = 3'b010)
//  G_ID         0   constant value driven on m_axi_awid/arid
// PORTS
//  s_aclk         in   1   clock, all logic on rising edge
//  s_aresetn      in   1   asynchronous active-low reset
//  cmd_valid      in   1   command offered
//  cmd_ready      out  1   command accepted when valid&ready
//  cmd_write      in   1   1 = write burst, 0 = read burst
//  cmd_addr       in   AW  byte start address
//  cmd_len        in   8   beats-1 (AXI LEN encoding)
//  wr_data/wr_strb  in  32/4  write stream payload
//  wr_valid/wr_ready  in/out  1  write stream handshake
//  rd_data        out  32  read stream payload (= m_axi_rdata)
//  rd_last        out  1   last beat of burst
//  rd_valid/rd_ready  out/in  1  read stream handshake
//  sts_valid      out  1   one-cycle pulse: command finished
//  sts_resp       out  2   worst response of the command
//  m_axi_aw*/w*/b*/ar*/r*   AXI4 master channels: id[0:0], addr[AW], len[8], size[3], burst[2],
//                           data[32], strb[4], last, resp[2], valid/ready, full AXI4 widths
// BEHAVIOUR
//  Reset: all m_axi_*valid, bready, rready, cmd_ready, wr_ready, rd_valid, sts_valid = 0; sts_resp = 0;
//   FSM -> IDLE; beat counter = 0. Reset mid-burst aborts immediately; no cleanup beats.
//  Constant outputs: awsize/arsize = 3'b010, awburst/arburst = 2'b01, awid/arid = G_ID.
//  FSM: IDLE, AW, W, B, AR, R, STS.
//   IDLE: cmd_ready=1. On accept, register addr/len/write; resp_acc=OKAY; cnt=0.
//    Illegal cmd (addr[1:0]!=0, or addr[11:0]+4*(len+1) > 4096) -> STS with resp=2'b10; no bus traffic.
//    Else write -> AW, read -> AR.
//   AW: awvalid=1, addr/len stable until awready; then -> W. AW is issued before any W beat.
//   W: pass-through; wvalid=wr_valid, wr_ready=wready, wdata/wstrb=wr_*.
//    wlast = (cnt==len). cnt++ per beat; beat with wlast -> B.
//   B: bready=1; on bvalid: resp_acc = max(resp_acc, bresp) -> STS.
//   AR: arvalid=1 until arready -> R.
//   R: rready=rd_ready, rd_valid=rvalid, rd_data=rdata, rd_last=rlast. Per beat: resp_acc=max(resp_acc,rresp); cnt++.
//    rlast on beat cnt!=len, or cnt==len without rlast -> resp_acc=2'b10.
//    Exit R on beat with rlast; if rlast never comes, leave R after beat len+1 beats.
//   STS: sts_valid=1 for exactly one cycle, sts_resp=resp_acc -> IDLE. cmd_ready=0 in STS.
//  Latency: cmd accept -> awvalid/arvalid next cycle; last B/R beat -> sts_valid next cycle.
//   Best-case back-to-back command throughput is len+5 cycles (write).
//  Valids never drop before ready; payload is stable while valid&!ready (AXI rule). Zero-wait and stalls both supported.
//  len=0: single beat, wlast is asserted on the first beat.
//  len=255 at a 4 KB-aligned addr (1 KB) is legal; cnt is 8 bits and holds len without wrapping.
// STRUCTURE
//  Package axi_burst_master_pkg:
//   - state_t enum
//   - AXI constants: RESP_OKAY/EXOKAY/SLVERR/DECERR, BURST_INCR, SIZE_4B
//   - function worst_resp(a,b)
//  Single module, no sub-module. Pass-through channels are combinational; FSM, counter and registers are flopped.
// TESTING (bench: this master -> 1024x32 memory slave)
//  Write addr 0x0, len 3, data 0x11..0x44 -> 4 W beats, wlast on beat 4, sts_resp=00.
//   Read back the same -> rd_data 0x11,0x22,0x33,0x44, rd_last on 4th beat.
//  Random wr_valid gaps and rd_ready backpressure, len 15 -> data intact, no beat dropped or duplicated.
//  cmd_addr 0xFF0, len 7 (crosses 4 KB) -> no awvalid, sts_valid within 2 cycles, sts_resp=10.
//  len 0 write 0xDEADBEEF to 0x3FC, then read back -> single beat, wlast=1, value matches.
//  Slave model returns bresp=10 -> sts_resp=10.
//   Early rlast on beat 2 of len 3 -> sts_resp=10, FSM returns to IDLE.
//  Assert s_aresetn low mid-W-burst -> all valids 0 within the same cycle, cmd_ready=1 after release.

Source files
------------

// File: rtl/axi_burst_master_pkg.sv
// Shared types and AXI4 encodings for the single-outstanding burst master.
package axi_burst_master_pkg;

  // Controller states: one command is in flight from IDLE until STS.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_STS
  } state_t;

  // AXI response encodings, ordered so that a larger value is a worse outcome.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Only incrementing bursts of 4-byte beats are generated.
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;

  // A burst must not run past the end of its 4 KB page.
  localparam logic [12:0] PAGE_BYTES = 13'd4096;

  // Keep the more severe of two responses.
  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 master: converts a command plus write/read data
// streams into INCR bursts and reports one status pulse per command.
module axi_burst_master
  import axi_burst_master_pkg::*;
#(
  parameter int          G_ADDRWIDTH = 32,
  parameter int          G_DATAWIDTH = 32,
  parameter logic [0:0]  G_ID        = 1'b0
) (
  input  logic                       s_aclk,
  input  logic                       s_aresetn,

  // command interface
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [G_ADDRWIDTH-1:0]     cmd_addr,
  input  logic [7:0]                 cmd_len,

  // write data stream
  input  logic [G_DATAWIDTH-1:0]     wr_data,
  input  logic [G_DATAWIDTH/8-1:0]   wr_strb,
  input  logic                       wr_valid,
  output logic                       wr_ready,

  // read data stream
  output logic [G_DATAWIDTH-1:0]     rd_data,
  output logic                       rd_last,
  output logic                       rd_valid,
  input  logic                       rd_ready,

  // completion status
  output logic                       sts_valid,
  output logic [1:0]                 sts_resp,

  // AXI4 write address channel
  output logic [0:0]                 m_axi_awid,
  output logic [G_ADDRWIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                 m_axi_awlen,
  output logic [2:0]                 m_axi_awsize,
  output logic [1:0]                 m_axi_awburst,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,

  // AXI4 write data channel
  output logic [G_DATAWIDTH-1:0]     m_axi_wdata,
  output logic [G_DATAWIDTH/8-1:0]   m_axi_wstrb,
  output logic                       m_axi_wlast,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,

  // AXI4 write response channel
  input  logic [1:0]                 m_axi_bresp,
  input  logic                       m_axi_bvalid,
  output logic                       m_axi_bready,

  // AXI4 read address channel
  output logic [0:0]                 m_axi_arid,
  output logic [G_ADDRWIDTH-1:0]     m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,

  // AXI4 read data channel
  input  logic [G_DATAWIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready
);

  state_t                  state_q, state_d;
  logic [G_ADDRWIDTH-1:0]  addr_q;
  logic [7:0]              len_q;
  logic [7:0]              cnt_q;
  logic [1:0]              resp_q;
  logic                    run_q;

  logic                    cmd_accept;
  logic                    cmd_illegal;
  logic [12:0]             cmd_end;
  logic                    last_beat;
  logic                    w_beat;
  logic                    r_beat;
  logic                    r_proto_err;

  // Byte offset one past the final beat, measured from the start of the page.
  assign cmd_end     = {1'b0, cmd_addr[11:0]} + {2'b00, ({1'b0, cmd_len} + 9'd1), 2'b00};
  assign cmd_illegal = (cmd_addr[1:0] != 2'b00) || (cmd_end > PAGE_BYTES);

  assign cmd_accept  = cmd_valid && cmd_ready;
  assign last_beat   = (cnt_q == len_q);
  assign w_beat      = (state_q == ST_W) && wr_valid && m_axi_wready;
  assign r_beat      = (state_q == ST_R) && m_axi_rvalid && rd_ready;
  // rlast must coincide exactly with the beat the counter expects to be final.
  assign r_proto_err = (m_axi_rlast != last_beat);

  // Fixed burst attributes and registered address/length.
  assign m_axi_awid    = G_ID;
  assign m_axi_arid    = G_ID;
  assign m_axi_awsize  = SIZE_4B;
  assign m_axi_arsize  = SIZE_4B;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_arlen   = len_q;

  // Payload pass-through; only the handshakes are gated by the FSM.
  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = wr_strb;
  assign rd_data       = m_axi_rdata;

  // State register.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would make results depend on process order.
    if (!s_aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Holds cmd_ready low while reset is asserted and for the first cycle after release.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Command registers, beat counter and accumulated worst response.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      resp_q <= RESP_OKAY;
    end else begin
      if (cmd_accept) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        cnt_q  <= '0;
        resp_q <= cmd_illegal ? RESP_SLVERR : RESP_OKAY;
      end
      if (w_beat) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if ((state_q == ST_B) && m_axi_bvalid) begin
        resp_q <= worst_resp(resp_q, m_axi_bresp);
      end
      if (r_beat) begin
        cnt_q  <= cnt_q + 8'd1;
        resp_q <= worst_resp(worst_resp(resp_q, m_axi_rresp),
                             r_proto_err ? RESP_SLVERR : RESP_OKAY);
      end
    end
  end

  // Next-state logic and per-state handshake outputs.
  always_comb begin
    // NOTE: every signal assigned below gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    cmd_ready     = 1'b0;
    wr_ready      = 1'b0;
    rd_valid      = 1'b0;
    rd_last       = 1'b0;
    sts_valid     = 1'b0;
    sts_resp      = RESP_OKAY;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = run_q;
        if (cmd_valid && run_q) begin
          if (cmd_illegal) begin
            state_d = ST_STS;
          end else if (cmd_write) begin
            state_d = ST_AW;
          end else begin
            state_d = ST_AR;
          end
        end
      end

      ST_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) begin
          state_d = ST_W;
        end
      end

      ST_W: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        m_axi_wlast  = last_beat;
        if (w_beat && last_beat) begin
          state_d = ST_B;
        end
      end

      ST_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          state_d = ST_STS;
        end
      end

      ST_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          state_d = ST_R;
        end
      end

      ST_R: begin
        m_axi_rready = rd_ready;
        rd_valid     = m_axi_rvalid;
        rd_last      = m_axi_rlast;
        // Leave on rlast, or after len+1 beats if the slave never sends it.
        if (r_beat && (m_axi_rlast || last_beat)) begin
          state_d = ST_STS;
        end
      end

      ST_STS: begin
        sts_valid = 1'b1;
        sts_resp  = resp_q;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
